// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared encodings for the pipeline stall/flush sequencer: PC-source select,
// FSM states, the ID-stage action picked in IDLE, and the control bundle.
package pipe_hazard_ctrl_pkg;

  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    PC_SEL_SEQ = 2'b00,
    PC_SEL_BR  = 2'b01,
    PC_SEL_RET = 2'b10,
    PC_SEL_VEC = 2'b11
  } pc_sel_e;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_RET_WAIT  = 3'd1,
    ST_RET_PC    = 3'd2,
    ST_INT_DRAIN = 3'd3,
    ST_INT_PUSH  = 3'd4,
    ST_INT_VEC   = 3'd5
  } state_e;

  // What IDLE does this cycle, already resolved by priority.
  typedef enum logic [2:0] {
    ACT_NONE,
    ACT_BR,
    ACT_RET,
    ACT_LU,
    ACT_INT
  } idle_act_e;

  typedef struct packed {
    logic    stall_f;
    logic    stall_d;
    logic    flush_d;
    logic    flush_e;
    pc_sel_e pc_sel;
    logic    int_ack;
    logic    int_push;
  } ctrl_t;

  // A wait of N cycles loads N-1 because the count includes the zero cycle.
  function automatic logic [CNT_W-1:0] cnt_load(input int unsigned cycles);
    return CNT_W'(cycles - 1);
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-control bus between the pipeline datapath (master) and the
// stall/flush sequencer (slave).
interface pipe_hazard_ctrl_if #(
  parameter int REG_AW = 2
);
  logic [REG_AW-1:0] src_a_D;
  logic [REG_AW-1:0] src_b_D;
  logic              use_a_D;
  logic              use_b_D;
  logic [REG_AW-1:0] dst_E;
  logic              wr_en_regf_E;
  logic              rd_en_E;
  logic              branch_taken_E;
  logic              is_ret_E;
  logic              intr;

  logic              stall_F;
  logic              stall_D;
  logic              flush_D;
  logic              flush_E;
  logic [1:0]        pc_sel;
  logic              int_ack;
  logic              int_push;
  logic              busy;

  modport master (
    output src_a_D, src_b_D, use_a_D, use_b_D, dst_E, wr_en_regf_E, rd_en_E,
           branch_taken_E, is_ret_E, intr,
    input  stall_F, stall_D, flush_D, flush_E, pc_sel, int_ack, int_push, busy
  );

  modport slave (
    input  src_a_D, src_b_D, use_a_D, use_b_D, dst_E, wr_en_regf_E, rd_en_E,
           branch_taken_E, is_ret_E, intr,
    output stall_F, stall_D, flush_D, flush_E, pc_sel, int_ack, int_push, busy
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: same-cycle load-use and
// branch handling, plus a counted FSM for RET/RTI bubbles and interrupt entry.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int REG_AW       = 2,
  parameter int RET_BUBBLES  = 2,
  parameter int DRAIN_CYCLES = 2
) (
  input logic               clk,
  input logic               reset,
  pipe_hazard_ctrl_if.slave hz
);

  localparam logic [CNT_W-1:0] RET_LOAD   = cnt_load(RET_BUBBLES);
  localparam logic [CNT_W-1:0] DRAIN_LOAD = cnt_load(DRAIN_CYCLES);

  state_e            state;
  logic [CNT_W-1:0]  cnt;
  logic              intr_q;
  logic              intr_pend;
  logic              int_resume;

  logic [REG_AW-1:0] src_a;
  logic [REG_AW-1:0] src_b;
  logic [REG_AW-1:0] dst;
  logic              lu;
  logic              intr_rise;
  idle_act_e         act;
  ctrl_t             ctl;

  assign src_a = hz.src_a_D;
  assign src_b = hz.src_b_D;
  assign dst   = hz.dst_E;

  assign lu = hz.rd_en_E & hz.wr_en_regf_E &
              ((hz.use_a_D & (src_a == dst)) | (hz.use_b_D & (src_b == dst)));

  assign intr_rise = hz.intr & ~intr_q;

  // A taken branch squashes the ID instruction, so it outranks a load-use.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    act = ACT_NONE;
    if (hz.branch_taken_E)  act = ACT_BR;
    else if (hz.is_ret_E)   act = ACT_RET;
    else if (lu)            act = ACT_LU;
    else if (intr_pend)     act = ACT_INT;
  end

  always_comb begin
    ctl        = '0;
    ctl.pc_sel = PC_SEL_SEQ;
    case (state)
      ST_IDLE: begin
        case (act)
          ACT_BR: begin
            ctl.flush_d = 1'b1;
            ctl.flush_e = 1'b1;
            ctl.pc_sel  = PC_SEL_BR;
          end
          ACT_RET: begin
            ctl.stall_f = 1'b1;
            ctl.flush_d = 1'b1;
          end
          ACT_LU: begin
            ctl.stall_f = 1'b1;
            ctl.stall_d = 1'b1;
            ctl.flush_e = 1'b1;
          end
          ACT_INT: begin
            ctl.int_ack = 1'b1;
            ctl.stall_f = 1'b1;
            ctl.flush_d = 1'b1;
          end
          default: ;
        endcase
      end
      ST_RET_WAIT: begin
        ctl.stall_f = 1'b1;
        ctl.flush_d = 1'b1;
      end
      ST_RET_PC: begin
        ctl.flush_d = 1'b1;
        ctl.pc_sel  = PC_SEL_RET;
      end
      ST_INT_DRAIN: begin
        ctl.stall_f = 1'b1;
        ctl.flush_d = 1'b1;
        if (hz.branch_taken_E) begin
          ctl.flush_e = 1'b1;
          ctl.pc_sel  = PC_SEL_BR;
        end
      end
      ST_INT_PUSH: begin
        ctl.int_push = 1'b1;
        ctl.stall_f  = 1'b1;
        ctl.flush_d  = 1'b1;
      end
      ST_INT_VEC: begin
        ctl.flush_d = 1'b1;
        ctl.pc_sel  = PC_SEL_VEC;
      end
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      intr_q     <= 1'b0;
      intr_pend  <= 1'b0;
      int_resume <= 1'b0;
    end else begin
      intr_q <= hz.intr;
      // A fresh edge in the ack cycle is a new request and must survive.
      if (intr_rise)        intr_pend <= 1'b1;
      else if (ctl.int_ack) intr_pend <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (act == ACT_RET) begin
            cnt   <= RET_LOAD;
            state <= ST_RET_WAIT;
          end else if (act == ACT_INT) begin
            cnt   <= DRAIN_LOAD;
            state <= ST_INT_DRAIN;
          end
        end
        ST_RET_WAIT: begin
          if (cnt == '0) state <= ST_RET_PC;
          else           cnt   <= cnt - CNT_W'(1);
        end
        ST_RET_PC: begin
          if (int_resume) begin
            int_resume <= 1'b0;
            cnt        <= DRAIN_LOAD;
            state      <= ST_INT_DRAIN;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_INT_DRAIN: begin
          if (hz.branch_taken_E) begin
            cnt <= DRAIN_LOAD;
          end else if (hz.is_ret_E) begin
            // Finish the return first, then restart the drain from RET_PC.
            int_resume <= 1'b1;
            cnt        <= RET_LOAD;
            state      <= ST_RET_WAIT;
          end else if (cnt == '0) begin
            state <= ST_INT_PUSH;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        ST_INT_PUSH: state <= ST_INT_VEC;
        ST_INT_VEC:  state <= ST_IDLE;
        default:     state <= ST_IDLE;
      endcase
    end
  end

  // Outputs are held low for the whole time reset is asserted, not just after an edge.
  assign hz.stall_F  = reset & ctl.stall_f;
  assign hz.stall_D  = reset & ctl.stall_d;
  assign hz.flush_D  = reset & ctl.flush_d;
  assign hz.flush_E  = reset & ctl.flush_e;
  assign hz.pc_sel   = reset ? ctl.pc_sel : PC_SEL_SEQ;
  assign hz.int_ack  = reset & ctl.int_ack;
  assign hz.int_push = reset & ctl.int_push;
  assign hz.busy     = reset & (state != ST_IDLE);

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: one-cycle vector records covering
// the same-cycle hazards and the RET / interrupt multi-cycle sequences.
module tb_pipe_hazard_ctrl;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  pipe_hazard_ctrl_if #(.REG_AW(2)) hz ();

  pipe_hazard_ctrl #(
    .REG_AW      (2),
    .RET_BUBBLES (2),
    .DRAIN_CYCLES(2)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .hz   (hz)
  );

  // exp packs {stall_F, stall_D, flush_D, flush_E, pc_sel[1:0], int_ack, int_push, busy}
  typedef struct {
    string      name;
    logic [1:0] sa, sb, de;
    logic       ua, ub, wr, rd, br, ret, intr;
    logic [8:0] exp;
  } vec_t;

  localparam logic [8:0] O_IDLE  = 9'b0_0_0_0_00_0_0_0;
  localparam logic [8:0] O_LU    = 9'b1_1_0_1_00_0_0_0;
  localparam logic [8:0] O_BR    = 9'b0_0_1_1_01_0_0_0;
  localparam logic [8:0] O_RET0  = 9'b1_0_1_0_00_0_0_0;
  localparam logic [8:0] O_WAIT  = 9'b1_0_1_0_00_0_0_1;
  localparam logic [8:0] O_RETPC = 9'b0_0_1_0_10_0_0_1;
  localparam logic [8:0] O_ACK   = 9'b1_0_1_0_00_1_0_0;
  localparam logic [8:0] O_DRBR  = 9'b1_0_1_1_01_0_0_1;
  localparam logic [8:0] O_PUSH  = 9'b1_0_1_0_00_0_1_1;
  localparam logic [8:0] O_VEC   = 9'b0_0_1_0_11_0_0_1;

  int   checks = 0;
  int   errors = 0;
  int   ack_seen;
  vec_t seq[$];

  function automatic vec_t mk(input string n, input logic [1:0] sa, input logic [1:0] sb,
                              input logic ua, input logic ub, input logic [1:0] de,
                              input logic wr, input logic rd, input logic br,
                              input logic ret, input logic intr, input logic [8:0] exp);
    vec_t v;
    v.name = n; v.sa = sa; v.sb = sb; v.ua = ua; v.ub = ub; v.de = de;
    v.wr = wr; v.rd = rd; v.br = br; v.ret = ret; v.intr = intr; v.exp = exp;
    return v;
  endfunction

  function automatic vec_t ctl(input string n, input logic br, input logic ret,
                               input logic intr, input logic [8:0] exp);
    return mk(n, 2'd0, 2'd0, 1'b0, 1'b0, 2'd1, 1'b0, 1'b0, br, ret, intr, exp);
  endfunction

  function automatic logic [8:0] outs();
    return {hz.stall_F, hz.stall_D, hz.flush_D, hz.flush_E, hz.pc_sel,
            hz.int_ack, hz.int_push, hz.busy};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    hz.src_a_D        = v.sa;
    hz.src_b_D        = v.sb;
    hz.use_a_D        = v.ua;
    hz.use_b_D        = v.ub;
    hz.dst_E          = v.de;
    hz.wr_en_regf_E   = v.wr;
    hz.rd_en_E        = v.rd;
    hz.branch_taken_E = v.br;
    hz.is_ret_E       = v.ret;
    hz.intr           = v.intr;
  endtask

  // One record per clock: drive just after the edge, compare mid-cycle.
  task automatic run_seq();
    ack_seen = 0;
    foreach (seq[i]) begin
      drive(seq[i]);
      #2;
      check(seq[i].name, 32'(outs()), 32'(seq[i].exp));
      ack_seen += int'(hz.int_ack);
      @(posedge clk);
      #1;
    end
    seq.delete();
  endtask

  initial begin
    // Reset with a load-use and a branch presented: outputs must stay 0.
    reset = 1'b0;
    drive(mk("rst", 2'd1, 2'd0, 1'b1, 1'b0, 2'd1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, O_IDLE));
    #3;
    check("reset_outputs", 32'(outs()), 32'(O_IDLE));
    #4;
    check("reset_after_edge", 32'(outs()), 32'(O_IDLE));
    drive(ctl("idle", 1'b0, 1'b0, 1'b0, O_IDLE));
    #5;
    reset = 1'b1;
    @(posedge clk);
    #1;

    // Same-cycle hazards in IDLE.
    //                 name           sa    sb    ua ub  de    wr rd br ret intr exp
    seq.push_back(mk("lu_src_a",     2'd1, 2'd0, 1, 0, 2'd1, 1, 1, 0, 0, 0, O_LU));
    seq.push_back(mk("lu_released",  2'd1, 2'd0, 0, 0, 2'd1, 1, 1, 0, 0, 0, O_IDLE));
    seq.push_back(mk("lu_src_b",     2'd0, 2'd2, 1, 1, 2'd2, 1, 1, 0, 0, 0, O_LU));
    seq.push_back(mk("lu_held",      2'd0, 2'd2, 1, 1, 2'd2, 1, 1, 0, 0, 0, O_LU));
    seq.push_back(mk("no_load",      2'd1, 2'd0, 1, 0, 2'd1, 1, 0, 0, 0, 0, O_IDLE));
    seq.push_back(mk("load_no_wr",   2'd1, 2'd0, 1, 0, 2'd1, 0, 1, 0, 0, 0, O_IDLE));
    seq.push_back(mk("reg_mismatch", 2'd3, 2'd2, 1, 1, 2'd1, 1, 1, 0, 0, 0, O_IDLE));
    seq.push_back(mk("br_over_lu",   2'd1, 2'd0, 1, 0, 2'd1, 1, 1, 1, 0, 0, O_BR));
    seq.push_back(mk("br_only",      2'd0, 2'd0, 0, 0, 2'd3, 0, 0, 1, 0, 0, O_BR));
    seq.push_back(mk("all_quiet",    2'd3, 2'd3, 0, 0, 2'd3, 0, 0, 0, 0, 0, O_IDLE));
    run_seq();

    // RET in IDLE: two frozen cycles, popped PC on the third, then IDLE.
    seq.push_back(ctl("ret_t0",   0, 1, 0, O_RET0));
    seq.push_back(ctl("ret_w1",   0, 0, 0, O_WAIT));
    seq.push_back(ctl("ret_w2",   0, 0, 0, O_WAIT));
    seq.push_back(ctl("ret_pc",   0, 0, 0, O_RETPC));
    seq.push_back(ctl("ret_idle", 0, 0, 0, O_IDLE));
    run_seq();

    // Interrupt entry: ack, two drain cycles, push, vector, IDLE.
    seq.push_back(ctl("int_req",   0, 0, 1, O_IDLE));
    seq.push_back(ctl("int_ack",   0, 0, 0, O_ACK));
    seq.push_back(ctl("int_dr1",   0, 0, 0, O_WAIT));
    seq.push_back(ctl("int_dr2",   0, 0, 0, O_WAIT));
    seq.push_back(ctl("int_push",  0, 0, 0, O_PUSH));
    seq.push_back(ctl("int_vec",   0, 0, 0, O_VEC));
    seq.push_back(ctl("int_idle",  0, 0, 0, O_IDLE));
    seq.push_back(ctl("int_quiet", 0, 0, 0, O_IDLE));
    run_seq();
    check("int_ack_count", 32'(ack_seen), 32'd1);

    // RET arriving during the drain: return completes, drain restarts.
    seq.push_back(ctl("rd_req",   0, 0, 1, O_IDLE));
    seq.push_back(ctl("rd_ack",   0, 0, 0, O_ACK));
    seq.push_back(ctl("rd_ret",   0, 1, 0, O_WAIT));
    seq.push_back(ctl("rd_w1",    0, 0, 0, O_WAIT));
    seq.push_back(ctl("rd_w2",    0, 0, 0, O_WAIT));
    seq.push_back(ctl("rd_retpc", 0, 0, 0, O_RETPC));
    seq.push_back(ctl("rd_dr1",   0, 0, 0, O_WAIT));
    seq.push_back(ctl("rd_dr2",   0, 0, 0, O_WAIT));
    seq.push_back(ctl("rd_push",  0, 0, 0, O_PUSH));
    seq.push_back(ctl("rd_vec",   0, 0, 0, O_VEC));
    seq.push_back(ctl("rd_idle",  0, 0, 0, O_IDLE));
    run_seq();
    check("ret_drain_ack_count", 32'(ack_seen), 32'd1);

    // Branch during the drain redirects and reloads the drain count.
    seq.push_back(ctl("bd_req",  0, 0, 1, O_IDLE));
    seq.push_back(ctl("bd_ack",  0, 0, 0, O_ACK));
    seq.push_back(ctl("bd_br",   1, 0, 0, O_DRBR));
    seq.push_back(ctl("bd_dr1",  0, 0, 0, O_WAIT));
    seq.push_back(ctl("bd_dr2",  0, 0, 0, O_WAIT));
    seq.push_back(ctl("bd_push", 0, 0, 0, O_PUSH));
    seq.push_back(ctl("bd_vec",  0, 0, 0, O_VEC));
    seq.push_back(ctl("bd_idle", 0, 0, 0, O_IDLE));
    run_seq();

    // Interrupt edge while busy with RET is held and taken back in IDLE.
    seq.push_back(ctl("pd_ret",   0, 1, 1, O_RET0));
    seq.push_back(ctl("pd_w1",    0, 0, 1, O_WAIT));
    seq.push_back(ctl("pd_w2",    0, 0, 0, O_WAIT));
    seq.push_back(ctl("pd_retpc", 0, 0, 0, O_RETPC));
    seq.push_back(ctl("pd_ack",   0, 0, 0, O_ACK));
    seq.push_back(ctl("pd_dr1",   0, 0, 0, O_WAIT));
    seq.push_back(ctl("pd_dr2",   0, 0, 0, O_WAIT));
    seq.push_back(ctl("pd_push",  0, 0, 0, O_PUSH));
    seq.push_back(ctl("pd_vec",   0, 0, 0, O_VEC));
    seq.push_back(ctl("pd_idle",  0, 0, 0, O_IDLE));
    run_seq();
    check("pend_ack_count", 32'(ack_seen), 32'd1);

    // Reset asserted during INT_PUSH aborts immediately; no push afterwards.
    seq.push_back(ctl("ra_req", 0, 0, 1, O_IDLE));
    seq.push_back(ctl("ra_ack", 0, 0, 0, O_ACK));
    seq.push_back(ctl("ra_dr1", 0, 0, 0, O_WAIT));
    seq.push_back(ctl("ra_dr2", 0, 0, 0, O_WAIT));
    run_seq();
    drive(ctl("idle", 1'b0, 1'b0, 1'b0, O_IDLE));
    #2;
    check("ra_push_reached", 32'(outs()), 32'(O_PUSH));
    reset = 1'b0;
    #1;
    check("ra_reset_immediate", 32'(outs()), 32'(O_IDLE));
    @(posedge clk);
    #4;
    check("ra_reset_held", 32'(outs()), 32'(O_IDLE));
    reset = 1'b1;
    @(posedge clk);
    #1;
    seq.push_back(ctl("ra_post1", 0, 0, 0, O_IDLE));
    seq.push_back(ctl("ra_post2", 0, 0, 0, O_IDLE));
    seq.push_back(ctl("ra_post3", 0, 0, 0, O_IDLE));
    seq.push_back(ctl("ra_post4", 0, 0, 0, O_IDLE));
    run_seq();
    check("ra_no_ack_after", 32'(ack_seen), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
